// File: rtl/audio_dac_tx.sv
// audio_dac_tx: double-buffered I2S transmitter for the codec DAC.
// Captures parallel left/right samples into holding registers, moves them into
// frame registers once per frame, and shifts them out MSB first while
// generating the bit clock and LR clock from AUDIO_CLK. The LR clock also paces
// the upstream synthesizer, so this block sets the audio sample rate.
// Optional build macro: AUD_LEFTJUST_EN selects left-justified framing
// (MSB coincident with the LRCK edge) instead of I2S.
module audio_dac_tx #(
    parameter int AUD_BIT_DEPTH = 24,
    parameter int SLOT_BITS     = 32,
    parameter int BCLK_DIV      = 4
) (
    input  logic                     AUDIO_CLK,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [AUD_BIT_DEPTH-1:0] lsound_in,
    input  logic [AUD_BIT_DEPTH-1:0] rsound_in,
    input  logic                     sample_valid,
    input  logic                     underrun_clr,
    output logic                     AUD_BCLK,
    output logic                     AUD_DACLRCK,
    output logic                     AUD_DACDAT,
    output logic                     frame_req,
    output logic                     underrun
);

    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int DW         = $clog2(BCLK_DIV);
    localparam int BW         = $clog2(FRAME_BITS);

    localparam logic [DW-1:0] D_LAST  = DW'(BCLK_DIV - 1);
    localparam logic [DW-1:0] D_HALF  = DW'(BCLK_DIV / 2);
    localparam logic [BW-1:0] B_LAST  = BW'(FRAME_BITS - 1);
    localparam logic [BW-1:0] B_SLOT  = BW'(SLOT_BITS);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t state_q, state_n;

    logic [DW-1:0] d_q, d_n;
    logic [BW-1:0] b_q, b_n;
    logic          load;

    logic [AUD_BIT_DEPTH-1:0] hl_q, hr_q;
    logic [AUD_BIT_DEPTH-1:0] fl_q, fr_q;
    logic [AUD_BIT_DEPTH-1:0] fl_n, fr_n;
    logic                     fresh_q;

    logic [BW-1:0]            slot;
    logic [AUD_BIT_DEPTH-1:0] sample_sel;
    logic                     running_n;
    logic                     bclk_n;
    logic                     lrck_n;
    logic                     dat_n;

    // Sequencer: run/idle decision, divider and bit counters, frame-load point
    always_comb begin
        state_n = state_q;
        d_n     = '0;
        b_n     = '0;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_n = ST_RUN;
                    load    = 1'b1;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_n = ST_IDLE;
                end else if (d_q == D_LAST) begin
                    if (b_q == B_LAST) begin
                        load = 1'b1;
                    end else begin
                        b_n = b_q + 1'b1;
                    end
                end else begin
                    d_n = d_q + 1'b1;
                    b_n = b_q;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Next frame contents and serial output bits, derived from post-edge counters
    always_comb begin
        fl_n = fl_q;
        fr_n = fr_q;
        if (load) begin
            fl_n = sample_valid ? lsound_in : hl_q;
            fr_n = sample_valid ? rsound_in : hr_q;
        end

        running_n  = (state_n == ST_RUN);
        lrck_n     = running_n && (b_n >= B_SLOT);
        bclk_n     = running_n && (d_n >= D_HALF);
        slot       = (b_n >= B_SLOT) ? (b_n - B_SLOT) : b_n;
        sample_sel = (b_n >= B_SLOT) ? fr_n : fl_n;

        dat_n = 1'b0;
        for (int i = 0; i < AUD_BIT_DEPTH; i++) begin
`ifdef AUD_LEFTJUST_EN
            if (slot == BW'(AUD_BIT_DEPTH - 1 - i)) begin
                dat_n = sample_sel[i];
            end
`else
            if (slot == BW'(AUD_BIT_DEPTH - i)) begin
                dat_n = sample_sel[i];
            end
`endif
        end
        dat_n = dat_n && running_n;
    end

    // State and counter registers
    always_ff @(posedge AUDIO_CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            d_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_n;
            d_q     <= d_n;
            b_q     <= b_n;
        end
    end

    // Holding registers capture every strobe; fresh marks an unconsumed sample
    always_ff @(posedge AUDIO_CLK or negedge reset_n) begin
        if (!reset_n) begin
            hl_q    <= '0;
            hr_q    <= '0;
            fresh_q <= 1'b0;
        end else begin
            if (sample_valid) begin
                hl_q <= lsound_in;
                hr_q <= rsound_in;
            end
            if (load) begin
                fresh_q <= 1'b0;
            end else if (sample_valid) begin
                fresh_q <= 1'b1;
            end
        end
    end

    // Frame registers hold the sample pair being shifted out this frame
    always_ff @(posedge AUDIO_CLK or negedge reset_n) begin
        if (!reset_n) begin
            fl_q <= '0;
            fr_q <= '0;
        end else begin
            fl_q <= fl_n;
            fr_q <= fr_n;
        end
    end

    // Sticky underrun: a load with no fresh sample sets it, and setting beats clearing
    always_ff @(posedge AUDIO_CLK or negedge reset_n) begin
        if (!reset_n) begin
            underrun <= 1'b0;
        end else if (load && !fresh_q && !sample_valid) begin
            underrun <= 1'b1;
        end else if (underrun_clr) begin
            underrun <= 1'b0;
        end
    end

    // Registered serial outputs so the DAC sees glitch-free clocks and data
    always_ff @(posedge AUDIO_CLK or negedge reset_n) begin
        if (!reset_n) begin
            AUD_BCLK    <= 1'b0;
            AUD_DACLRCK <= 1'b0;
            AUD_DACDAT  <= 1'b0;
            frame_req   <= 1'b0;
        end else begin
            AUD_BCLK    <= bclk_n;
            AUD_DACLRCK <= lrck_n;
            AUD_DACDAT  <= dat_n;
            frame_req   <= load;
        end
    end

endmodule

// File: tb/tb_audio_dac_tx.sv
// tb_audio_dac_tx: randomized self-checking bench for audio_dac_tx.
// A frame-position reference model (cycles since the last load) predicts every
// output; scenario tasks also check fixed expectations from the test plan.
`timescale 1ns/1ps
module tb_audio_dac_tx;

    localparam int DEPTH = 24;
    localparam int SLOT  = 32;
    localparam int DIV   = 4;
    localparam int FRAME = 2 * SLOT * DIV;
`ifdef AUD_LEFTJUST_EN
    localparam int OFS = 0;
`else
    localparam int OFS = 1;
`endif

    logic             AUDIO_CLK = 1'b0;
    logic             reset_n;
    logic             enable = 1'b0;
    logic [DEPTH-1:0] lsound_in = '0;
    logic [DEPTH-1:0] rsound_in = '0;
    logic             sample_valid = 1'b0;
    logic             underrun_clr = 1'b0;
    logic             AUD_BCLK;
    logic             AUD_DACLRCK;
    logic             AUD_DACDAT;
    logic             frame_req;
    logic             underrun;

    int n_checks = 0;
    int n_pass   = 0;

    audio_dac_tx #(
        .AUD_BIT_DEPTH(DEPTH),
        .SLOT_BITS    (SLOT),
        .BCLK_DIV     (DIV)
    ) dut (
        .AUDIO_CLK   (AUDIO_CLK),
        .reset_n     (reset_n),
        .enable      (enable),
        .lsound_in   (lsound_in),
        .rsound_in   (rsound_in),
        .sample_valid(sample_valid),
        .underrun_clr(underrun_clr),
        .AUD_BCLK    (AUD_BCLK),
        .AUD_DACLRCK (AUD_DACLRCK),
        .AUD_DACDAT  (AUD_DACDAT),
        .frame_req   (frame_req),
        .underrun    (underrun)
    );

    always #5 AUDIO_CLK = ~AUDIO_CLK;

    logic [4:0] act;
    assign act = {AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, frame_req, underrun};

    // Reference model: frame position in AUDIO_CLK cycles plus sample bookkeeping
    bit               m_run;
    int               m_t;
    logic [DEPTH-1:0] m_hl, m_hr, m_fl, m_fr;
    bit               m_fresh, m_underrun, m_freq, m_ld;

    always_comb m_ld = m_run ? (enable && m_t == FRAME - 1) : enable;

    always @(posedge AUDIO_CLK or negedge reset_n) begin
        if (!reset_n) begin
            m_run <= 0; m_t <= 0; m_freq <= 0; m_fresh <= 0; m_underrun <= 0;
            m_hl <= '0; m_hr <= '0; m_fl <= '0; m_fr <= '0;
        end else begin
            if (!m_run) begin
                if (enable) begin m_run <= 1; m_t <= 0; end
            end else if (!enable) begin
                m_run <= 0; m_t <= 0;
            end else begin
                m_t <= (m_t + 1) % FRAME;
            end
            m_freq <= m_ld;
            if (m_ld) begin
                m_fl    <= sample_valid ? lsound_in : m_hl;
                m_fr    <= sample_valid ? rsound_in : m_hr;
                m_fresh <= 0;
                if (!m_fresh && !sample_valid) m_underrun <= 1;
                else if (underrun_clr) m_underrun <= 0;
            end else begin
                if (sample_valid) m_fresh <= 1;
                if (underrun_clr) m_underrun <= 0;
            end
            if (sample_valid) begin m_hl <= lsound_in; m_hr <= rsound_in; end
        end
    end

    function automatic logic [4:0] exp_outs();
        int bi, slot;
        logic bclk, lrck, dat;
        logic [DEPTH-1:0] smp;
        if (!m_run) return {4'b0000, m_underrun};
        bi   = m_t / DIV;
        bclk = (m_t % DIV) >= DIV / 2;
        lrck = bi >= SLOT;
        slot = bi % SLOT;
        smp  = lrck ? m_fr : m_fl;
`ifdef AUD_LEFTJUST_EN
        dat = (slot < DEPTH) ? (((smp >> (DEPTH - 1 - slot)) & DEPTH'(1)) != 0) : 1'b0;
`else
        dat = (slot >= 1 && slot <= DEPTH) ? (((smp >> (DEPTH - slot)) & DEPTH'(1)) != 0) : 1'b0;
`endif
        return {bclk, lrck, dat, m_freq, m_underrun};
    endfunction

    // Collects the left/right words of one frame; caller sits at the post-load negedge
    task automatic capture_frame(output logic [DEPTH-1:0] lw, output logic [DEPTH-1:0] rw);
        int bi;
        lw = '0;
        rw = '0;
        for (int k = 0; k < FRAME; k++) begin
            if (k > 0) @(negedge AUDIO_CLK);
            if (k % DIV == DIV / 2) begin
                bi = k / DIV;
                if (bi >= OFS && bi < OFS + DEPTH) lw = {lw[DEPTH-2:0], AUD_DACDAT};
                if (bi >= SLOT + OFS && bi < SLOT + OFS + DEPTH) rw = {rw[DEPTH-2:0], AUD_DACDAT};
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #2;
        reset_n      = 1'b0;
        enable       = 1'b1;
        sample_valid = 1'b1;
        lsound_in    = 24'($urandom);
        rsound_in    = 24'($urandom);
        for (int i = 0; i < 3; i++) begin
            @(negedge AUDIO_CLK);
            n_checks++;
            if (act !== 5'b0) $display("[TB] FAIL in_reset: got %b expected 00000", act);
            else n_pass++;
        end
        sample_valid = 1'b0;
        enable       = 1'b0;
        reset_n      = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge AUDIO_CLK);
            n_checks++;
            if (act !== 5'b0) $display("[TB] FAIL idle_after_reset: got %b expected 00000", act);
            else n_pass++;
        end
    endtask

    task automatic test_basic_frame();
        logic [DEPTH-1:0] lw, rw;
        int bi;
        @(negedge AUDIO_CLK);
        sample_valid = 1'b1;
        lsound_in    = 24'h800001;
        rsound_in    = 24'h7FFFFF;
        @(negedge AUDIO_CLK);
        sample_valid = 1'b0;
        enable       = 1'b1;
        @(negedge AUDIO_CLK);
        n_checks++;
        if ({AUD_BCLK, AUD_DACLRCK, frame_req} !== 3'b001)
            $display("[TB] FAIL first_load: got %b expected 001", {AUD_BCLK, AUD_DACLRCK, frame_req});
        else n_pass++;
        lw = '0;
        rw = '0;
        for (int k = 0; k < FRAME; k++) begin
            if (k > 0) @(negedge AUDIO_CLK);
            n_checks++;
            if (act !== exp_outs()) $display("[TB] FAIL basic_k%0d: got %b expected %b", k, act, exp_outs());
            else n_pass++;
            if (k == FRAME / 2 - 1 || k == FRAME / 2) begin
                n_checks++;
                if (AUD_DACLRCK !== logic'(k == FRAME / 2))
                    $display("[TB] FAIL lrck_edge_k%0d: got %b expected %b", k, AUD_DACLRCK, k == FRAME / 2);
                else n_pass++;
            end
            if (k % DIV == DIV / 2) begin
                bi = k / DIV;
                if (bi >= OFS && bi < OFS + DEPTH) lw = {lw[DEPTH-2:0], AUD_DACDAT};
                if (bi >= SLOT + OFS && bi < SLOT + OFS + DEPTH) rw = {rw[DEPTH-2:0], AUD_DACDAT};
            end
        end
        n_checks++;
        if (lw !== 24'h800001) $display("[TB] FAIL basic_left: got %h expected 800001", lw);
        else n_pass++;
        n_checks++;
        if (rw !== 24'h7FFFFF) $display("[TB] FAIL basic_right: got %h expected 7fffff", rw);
        else n_pass++;
    endtask

    task automatic test_underrun();
        logic [DEPTH-1:0] lw, rw;
        @(negedge AUDIO_CLK);
        n_checks++;
        if ({frame_req, underrun} !== 2'b11) $display("[TB] FAIL underrun_set: got %b expected 11", {frame_req, underrun});
        else n_pass++;
        capture_frame(lw, rw);
        n_checks++;
        if (lw !== 24'h800001 || rw !== 24'h7FFFFF)
            $display("[TB] FAIL underrun_repeat: got %h/%h expected 800001/7fffff", lw, rw);
        else n_pass++;
        underrun_clr = 1'b1;
        @(negedge AUDIO_CLK);
        n_checks++;
        if (underrun !== 1'b1) $display("[TB] FAIL set_beats_clear: got %b expected 1", underrun);
        else n_pass++;
        @(negedge AUDIO_CLK);
        underrun_clr = 1'b0;
        n_checks++;
        if (underrun !== 1'b0) $display("[TB] FAIL underrun_clear: got %b expected 0", underrun);
        else n_pass++;
    endtask

    task automatic test_collision();
        logic [DEPTH-1:0] lw, rw, rnd;
        for (int i = 0; i < FRAME + 8 && !(m_run && m_t == FRAME - 1); i++) @(negedge AUDIO_CLK);
        n_checks++;
        if (!(m_run && m_t == FRAME - 1)) $display("[TB] FAIL collision_wait: got %0d expected %0d", m_t, FRAME - 1);
        else n_pass++;
        rnd          = 24'($urandom);
        sample_valid = 1'b1;
        lsound_in    = 24'h123456;
        rsound_in    = rnd;
        @(negedge AUDIO_CLK);
        sample_valid = 1'b0;
        n_checks++;
        if ({frame_req, underrun} !== 2'b10) $display("[TB] FAIL collision_flags: got %b expected 10", {frame_req, underrun});
        else n_pass++;
        capture_frame(lw, rw);
        n_checks++;
        if (lw !== 24'h123456 || rw !== rnd)
            $display("[TB] FAIL collision_data: got %h/%h expected 123456/%h", lw, rw, rnd);
        else n_pass++;
    endtask

    task automatic test_midframe_stop();
        logic [DEPTH-1:0] lw, rw;
        for (int i = 0; i < FRAME + 8 && !(m_run && m_t == 40 * DIV); i++) @(negedge AUDIO_CLK);
        n_checks++;
        if (!(m_run && m_t == 40 * DIV) || AUD_DACLRCK !== 1'b1)
            $display("[TB] FAIL stop_wait: got t=%0d lrck=%b expected t=%0d lrck=1", m_t, AUD_DACLRCK, 40 * DIV);
        else n_pass++;
        enable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge AUDIO_CLK);
            n_checks++;
            if (act[4:1] !== 4'b0000) $display("[TB] FAIL stopped_c%0d: got %b expected 0000", i, act[4:1]);
            else n_pass++;
        end
        enable = 1'b1;
        @(negedge AUDIO_CLK);
        n_checks++;
        if (act[4:1] !== 4'b0001) $display("[TB] FAIL restart_load: got %b expected 0001", act[4:1]);
        else n_pass++;
        capture_frame(lw, rw);
        n_checks++;
        if (lw !== 24'h123456) $display("[TB] FAIL restart_data: got %h expected 123456", lw);
        else n_pass++;
    endtask

    task automatic test_random();
        enable = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge AUDIO_CLK);
            n_checks++;
            if (act !== exp_outs()) $display("[TB] FAIL random_c%0d: got %b expected %b", i, act, exp_outs());
            else n_pass++;
            sample_valid = ($urandom_range(0, 149) == 0) ||
                           (m_run && m_t == FRAME - 1 && $urandom_range(0, 2) == 0);
            lsound_in    = 24'($urandom);
            rsound_in    = 24'($urandom);
            underrun_clr = ($urandom_range(0, 299) == 0);
            enable       = ($urandom_range(0, 1999) != 0);
        end
        sample_valid = 1'b0;
        underrun_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_underrun();
        test_collision();
        test_midframe_stop();
        test_random();
        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
